div_iter: RTL and testbench

Iterative radix-2 divide/remainder unit for the RV32M datapath. The M-type execute stage hands DIV/DIVU/REM/REMU operations to this block instead of computing division combinationally, stalls while `busy` is high, and takes the 32-bit result on the `done` pulse for register writeback. One restoring-division step is performed per clock. RISC-V divide-by-zero and signed-overflow results are produced in a single cycle.

---
 rtl/div_iter.sv | 134 +++++++++++++
 tb/tb_div_iter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports: clk, rst (async, active-high), start/funct/rs1/rs2 request,
//   kill flush, busy while iterating, done pulse with registered result.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      funct,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t          state;
    logic            sel_rem;
    logic            q_neg;
    logic            r_neg;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [CW-1:0]   cnt;

    logic            s1;
    logic            s2;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign s1       = !funct[0] && rs1[XLEN-1];
    assign s2       = !funct[0] && rs2[XLEN-1];
    assign a_abs    = s1 ? -rs1 : rs1;
    assign b_abs    = s2 ? -rs2 : rs2;
    assign div_zero = (rs2 == '0);
    assign ovf      = !funct[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (rs2 == '1);

    // Partial remainder stays below the divisor, so after the shift it is
    // below 2*divisor; the sign bit of the XLEN+1-bit difference is
    // therefore an exact "less than" flag even for divisors >= 2^(XLEN-1).
    assign rem_sh  = {rem, quo[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign ge      = !diff[XLEN];

    assign quo_fix = q_neg ? -quo : quo;
    assign rem_fix = r_neg ? -rem : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel_rem <= 1'b0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            sel_rem <= funct[1];
                            q_neg   <= s1 ^ s2;
                            r_neg   <= s1;
                            dvs     <= b_abs;
                            quo     <= a_abs;
                            rem     <= '0;
                            cnt     <= CW'(XLEN);
                            if (div_zero) begin
                                result <= funct[1] ? rs1 : '1;
                                done   <= 1'b1;
                                state  <= DONE;
                            end else if (ovf) begin
                                result <= funct[1] ? '0 : rs1;
                                done   <= 1'b1;
                                state  <= DONE;
                            end else begin
                                busy  <= 1'b1;
                                state <= CALC;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    CALC: begin
                        rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], ge};
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        result <= sel_rem ? rem_fix : quo_fix;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: scoreboard bench for div_iter (directed, special, random,
//   back-to-back, kill and async reset scenarios).
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  funct;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int failures;
    logic [31:0] last_res;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div_iter #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct  (funct),
        .rs1    (rs1),
        .rs2    (rs2),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a request for one edge; afterwards we sit in cycle 1.
    task automatic issue(input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        funct = f;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1   = $urandom;
        rs2   = $urandom;
    endtask

    // Returns the cycle index (1 = cycle after accept) of the done pulse,
    // or -1 if it never came within the budget.
    task automatic wait_done(output int c, output logic [31:0] r,
                             output bit busy_any);
        c        = -1;
        r        = 'x;
        busy_any = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            if (busy) busy_any = 1'b1;
            if (done) begin
                c = i;
                r = result;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (!f[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    task automatic test_reset;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", result);
        end
    endtask

    task automatic test_directed;
        logic [1:0]  tf[9];
        logic [31:0] ta[9];
        logic [31:0] tb[9];
        logic [31:0] tr[9];
        int          tl[9];
        int          c;
        logic [31:0] r;
        bit          ba;
        exp_t        e;
        tf = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00, 2'b10,
               2'b01};
        ta = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
               32'h8000_0000};
        tb = '{32'd3, 32'd3, 32'h8000_0000, 32'h8000_0000,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        tr = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd1, 32'h7FFF_FFFF,
               32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'd0, 32'd0};
        tl = '{34, 34, 34, 34, 1, 1, 1, 1, 34};
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{res: tr[i], lat: tl[i]});
            issue(tf[i], ta[i], tb[i]);
            wait_done(c, r, ba);
            e = sb.pop_front();
            last_res = e.res;
            checks++;
            if (r !== e.res) begin
                failures++;
                $display("FAIL dir%0d_result got=%h exp=%h", i, r, e.res);
            end
            checks++;
            if (c !== e.lat) begin
                failures++;
                $display("FAIL dir%0d_done_cycle got=%0d exp=%0d",
                         i, c, e.lat);
            end
            checks++;
            if (ba !== (e.lat != 1)) begin
                failures++;
                $display("FAIL dir%0d_busy got=%b exp=%b",
                         i, ba, e.lat != 1);
            end
            tick(2);
        end
    endtask

    task automatic test_random;
        logic [1:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          c;
        logic [31:0] r;
        bit          ba;
        exp_t        e;
        for (int i = 0; i < 10; i++) begin
            f = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            sb.push_back('{res: ref_res(f, a, b),
                           lat: (b == 32'd0) ? 1 : 34});
            issue(f, a, b);
            wait_done(c, r, ba);
            e = sb.pop_front();
            last_res = e.res;
            checks++;
            if (r !== e.res) begin
                failures++;
                $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h exp=%h",
                         i, f, a, b, r, e.res);
            end
            checks++;
            if (c !== e.lat) begin
                failures++;
                $display("FAIL rnd%0d_done_cycle got=%0d exp=%0d",
                         i, c, e.lat);
            end
            tick(1);
        end
    endtask

    task automatic test_back_to_back;
        int          c1;
        int          c2;
        logic [31:0] r1;
        logic [31:0] r2;
        bit          ba;
        exp_t        e;
        sb.push_back('{res: 32'd14, lat: 34});
        issue(2'b00, 32'd100, 32'd7);
        wait_done(c1, r1, ba);
        sb.push_back('{res: 32'd2, lat: 34});
        issue(2'b11, 32'd100, 32'd7);
        wait_done(c2, r2, ba);
        e = sb.pop_front();
        checks++;
        if (r1 !== e.res || c1 !== e.lat) begin
            failures++;
            $display("FAIL b2b_first got=%h@%0d exp=%h@%0d",
                     r1, c1, e.res, e.lat);
        end
        e = sb.pop_front();
        last_res = e.res;
        checks++;
        if (r2 !== e.res) begin
            failures++;
            $display("FAIL b2b_second_result got=%h exp=%h", r2, e.res);
        end
        checks++;
        if (c1 + c2 !== 68) begin
            failures++;
            $display("FAIL b2b_second_cycle got=%0d exp=68", c1 + c2);
        end
        tick(2);
    endtask

    task automatic test_start_ignored;
        int          c;
        logic [31:0] r;
        bit          ba;
        bit          extra;
        exp_t        e;
        sb.push_back('{res: 32'd3, lat: 34});
        issue(2'b00, 32'd9, 32'd3);
        tick(4);
        funct = 2'b00;
        rs1   = 32'd5;
        rs2   = 32'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(c, r, ba);
        e = sb.pop_front();
        last_res = e.res;
        checks++;
        if (r !== e.res) begin
            failures++;
            $display("FAIL ign_result got=%h exp=%h", r, e.res);
        end
        checks++;
        if (c + 5 !== e.lat) begin
            failures++;
            $display("FAIL ign_done_cycle got=%0d exp=%0d", c + 5, e.lat);
        end
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (done) extra = 1'b1;
        end
        checks++;
        if (extra !== 1'b0) begin
            failures++;
            $display("FAIL ign_extra_done got=%b exp=0", extra);
        end
    endtask

    task automatic test_kill;
        bit seen;
        issue(2'b00, 32'd1000, 32'd10);
        tick(9);
        kill = 1'b1;
        tick(1);
        kill = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL kill_busy got=%b exp=0", busy);
        end
        checks++;
        if (result !== last_res) begin
            failures++;
            $display("FAIL kill_result got=%h exp=%h", result, last_res);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen = 1'b1;
            tick(1);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL kill_no_done got=%b exp=0", seen);
        end
        funct = 2'b00;
        rs1   = 32'd9;
        rs2   = 32'd0;
        start = 1'b1;
        kill  = 1'b1;
        tick(1);
        start = 1'b0;
        kill  = 1'b0;
        checks++;
        if (done !== 1'b0 || result !== last_res) begin
            failures++;
            $display("FAIL kill_drops_start got=%b/%h exp=0/%h",
                     done, result, last_res);
        end
        issue(2'b00, 32'd9, 32'd0);
        kill = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || result !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL kill_in_done got=%b/%h exp=1/ffffffff",
                     done, result);
        end
        last_res = 32'hFFFF_FFFF;
        tick(1);
        kill = 1'b0;
        tick(1);
    endtask

    task automatic test_async_rst;
        int          c;
        logic [31:0] r;
        bit          ba;
        exp_t        e;
        issue(2'b00, 32'd100, 32'd7);
        tick(19);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL arst_flags got=%b%b exp=00", busy, done);
        end
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL arst_result got=%h exp=0", result);
        end
        tick(2);
        rst = 1'b0;
        tick(1);
        sb.push_back('{res: 32'd3, lat: 34});
        issue(2'b00, 32'd9, 32'd3);
        wait_done(c, r, ba);
        e = sb.pop_front();
        last_res = e.res;
        checks++;
        if (r !== e.res || c !== e.lat) begin
            failures++;
            $display("FAIL arst_after_op got=%h@%0d exp=%h@%0d",
                     r, c, e.res, e.lat);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        last_res = 32'd0;
        rst      = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        funct    = 2'b00;
        rs1      = 32'd0;
        rs2      = 32'd0;
        tick(3);
        test_reset();
        rst = 1'b0;
        tick(1);
        test_directed();
        test_random();
        test_back_to_back();
        test_start_ignored();
        test_kill();
        test_async_rst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
